// File: rtl/gate_ctrl_pkg.sv
// Shared constants for the gate controller: FSM state encoding and the
// default scrub length.
package gate_ctrl_pkg;

    // FSM state encoding (plain constants so the flops stay ordinary registers)
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_SCRUB_IDLE = 2'd2;
    localparam logic [1:0] ST_SCRUB_RUN  = 2'd3;

    // Default number of forced gate-open cycles per scrub (legal 1..255)
    localparam int SCRUB_CYCLES_DEF = 4;

    // Scrub down-counter width, wide enough for the full legal scrub range
    localparam int SCRUB_CNT_W = 8;

endpackage

// File: rtl/gate_ctrl_err_sat_cnt.sv
// Saturating event counter for TMR voter mismatches. A clear that coincides
// with a new event leaves the count at 1 so that event is not lost.
module err_sat_cnt #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] count
);

    // Count events, sticking at all-ones; clear wins over increment except it keeps the current event
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ERR_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + ERR_W'(1);
        end
    end

endmodule

// File: rtl/gate_ctrl.sv
// Clock-gate sequencer: opens the datapath clock for a requested number of
// cycles and inserts forced scrub windows when the TMR voter flags a mismatch.
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   ST_IDLE       | gate closed, waiting for start or tmrError
//   ST_RUN        | gate open, run counter counting down the requested length
//   ST_SCRUB_IDLE | gate forced open for a scrub entered from idle
//   ST_SCRUB_RUN  | gate forced open for a scrub; run counter frozen
module gate_ctrl
    import gate_ctrl_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int ERR_W        = 8,
    parameter int SCRUB_CYCLES = SCRUB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             stop,
    input  logic             tmrError,
    input  logic             errClr,
    output logic             gate,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [ERR_W-1:0] errCount
);

    localparam logic [SCRUB_CNT_W-1:0] SCRUB_LD = SCRUB_CNT_W'(SCRUB_CYCLES);

    logic [1:0]             state;
    logic [1:0]             stateNext;
    logic [CNT_W-1:0]       runCnt;
    logic [CNT_W-1:0]       runCntNext;
    logic [SCRUB_CNT_W-1:0] scrubCnt;
    logic [SCRUB_CNT_W-1:0] scrubCntNext;
    logic                   doneNext;
    logic                   abortedNext;

    // Next-state decode; priority within a cycle is stop, then tmrError, then start
    always_comb begin
        stateNext    = state;
        runCntNext   = runCnt;
        scrubCntNext = scrubCnt;
        doneNext     = 1'b0;
        abortedNext  = 1'b0;

        case (state)
            ST_IDLE: begin
                // stop has nothing to abort here, so it is deliberately ignored
                if (tmrError) begin
                    stateNext    = ST_SCRUB_IDLE;
                    scrubCntNext = SCRUB_LD;
                end else if (start) begin
                    if (len != '0) begin
                        stateNext  = ST_RUN;
                        runCntNext = len;
                    end else begin
                        doneNext = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    stateNext   = ST_IDLE;
                    runCntNext  = '0;
                    abortedNext = 1'b1;
                end else begin
                    // this gate-high cycle counts toward len even if it triggers a scrub
                    runCntNext = runCnt - CNT_W'(1);
                    if (tmrError) begin
                        stateNext    = ST_SCRUB_RUN;
                        scrubCntNext = SCRUB_LD;
                    end else if (runCnt == CNT_W'(1)) begin
                        stateNext = ST_IDLE;
                        doneNext  = 1'b1;
                    end
                end
            end

            ST_SCRUB_IDLE, ST_SCRUB_RUN: begin
                if (stop) begin
                    stateNext    = ST_IDLE;
                    runCntNext   = '0;
                    scrubCntNext = '0;
                    abortedNext  = 1'b1;
                end else if (tmrError) begin
                    scrubCntNext = SCRUB_LD;
                end else if (scrubCnt == SCRUB_CNT_W'(1)) begin
                    scrubCntNext = '0;
                    if (state == ST_SCRUB_IDLE) begin
                        stateNext = ST_IDLE;
                    end else if (runCnt == '0) begin
                        // the run's last cycle raised the scrub; finish the run now
                        stateNext = ST_IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = ST_RUN;
                    end
                end else begin
                    scrubCntNext = scrubCnt - SCRUB_CNT_W'(1);
                end
            end

            default: begin
                stateNext    = ST_IDLE;
                runCntNext   = '0;
                scrubCntNext = '0;
            end
        endcase
    end

    // State, counters and all outputs are registered; gate follows the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            runCnt   <= '0;
            scrubCnt <= '0;
            gate     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= stateNext;
            runCnt   <= runCntNext;
            scrubCnt <= scrubCntNext;
            gate     <= (stateNext != ST_IDLE);
            busy     <= (stateNext != ST_IDLE);
            done     <= doneNext;
            aborted  <= abortedNext;
        end
    end

    err_sat_cnt #(
        .ERR_W (ERR_W)
    ) u_err_sat_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tmrError),
        .clr   (errClr),
        .count (errCount)
    );

endmodule
